// File: rtl/alu_decode_queue.sv
// Decoding instruction queue between fetch and ID/EX. Each instruction is decoded once on enqueue
// (ALU op, branch class, reserved flag) and held in a DEPTH-entry FIFO with flush and backpressure.
module alu_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int ALUOP_W = 8,
  parameter int PC_W    = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [ALUOP_W-1:0]       out_alucontrol,
  output logic [4:0]               out_branch_judge,
  output logic                     out_ri,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP     = ALUOP_W'(8'b00000000);
  localparam logic [ALUOP_W-1:0] EXE_AND_OP     = ALUOP_W'(8'b00100100);
  localparam logic [ALUOP_W-1:0] EXE_OR_OP      = ALUOP_W'(8'b00100101);
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP     = ALUOP_W'(8'b00100110);
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP     = ALUOP_W'(8'b00100111);
  localparam logic [ALUOP_W-1:0] EXE_ANDI_OP    = ALUOP_W'(8'b01011001);
  localparam logic [ALUOP_W-1:0] EXE_ORI_OP     = ALUOP_W'(8'b01011010);
  localparam logic [ALUOP_W-1:0] EXE_XORI_OP    = ALUOP_W'(8'b01011011);
  localparam logic [ALUOP_W-1:0] EXE_LUI_OP     = ALUOP_W'(8'b01011100);
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP     = ALUOP_W'(8'b01111100);
  localparam logic [ALUOP_W-1:0] EXE_SLLV_OP    = ALUOP_W'(8'b00000100);
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP     = ALUOP_W'(8'b00000010);
  localparam logic [ALUOP_W-1:0] EXE_SRLV_OP    = ALUOP_W'(8'b00000110);
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP     = ALUOP_W'(8'b00000011);
  localparam logic [ALUOP_W-1:0] EXE_SRAV_OP    = ALUOP_W'(8'b00000111);
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP    = ALUOP_W'(8'b00010000);
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP    = ALUOP_W'(8'b00010001);
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP    = ALUOP_W'(8'b00010010);
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP    = ALUOP_W'(8'b00010011);
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP     = ALUOP_W'(8'b00101010);
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP    = ALUOP_W'(8'b00101011);
  localparam logic [ALUOP_W-1:0] EXE_SLTI_OP    = ALUOP_W'(8'b01010111);
  localparam logic [ALUOP_W-1:0] EXE_SLTIU_OP   = ALUOP_W'(8'b01011000);
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP     = ALUOP_W'(8'b00100000);
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP    = ALUOP_W'(8'b00100001);
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP     = ALUOP_W'(8'b00100010);
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP    = ALUOP_W'(8'b00100011);
  localparam logic [ALUOP_W-1:0] EXE_ADDI_OP    = ALUOP_W'(8'b01010101);
  localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP   = ALUOP_W'(8'b01010110);
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP    = ALUOP_W'(8'b00011000);
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP   = ALUOP_W'(8'b00011001);
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP     = ALUOP_W'(8'b00011010);
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP    = ALUOP_W'(8'b00011011);
  localparam logic [ALUOP_W-1:0] EXE_J_OP       = ALUOP_W'(8'b01001111);
  localparam logic [ALUOP_W-1:0] EXE_JAL_OP     = ALUOP_W'(8'b01010000);
  localparam logic [ALUOP_W-1:0] EXE_JALR_OP    = ALUOP_W'(8'b00001001);
  localparam logic [ALUOP_W-1:0] EXE_BEQ_OP     = ALUOP_W'(8'b01010001);
  localparam logic [ALUOP_W-1:0] EXE_BNE_OP     = ALUOP_W'(8'b01010010);
  localparam logic [ALUOP_W-1:0] EXE_BLEZ_OP    = ALUOP_W'(8'b01010011);
  localparam logic [ALUOP_W-1:0] EXE_BGTZ_OP    = ALUOP_W'(8'b01010100);
  localparam logic [ALUOP_W-1:0] EXE_BLTZ_OP    = ALUOP_W'(8'b01000000);
  localparam logic [ALUOP_W-1:0] EXE_BGEZ_OP    = ALUOP_W'(8'b01000001);
  localparam logic [ALUOP_W-1:0] EXE_BLTZAL_OP  = ALUOP_W'(8'b01001010);
  localparam logic [ALUOP_W-1:0] EXE_BGEZAL_OP  = ALUOP_W'(8'b01001011);
  localparam logic [ALUOP_W-1:0] EXE_LB_OP      = ALUOP_W'(8'b11100000);
  localparam logic [ALUOP_W-1:0] EXE_LH_OP      = ALUOP_W'(8'b11100001);
  localparam logic [ALUOP_W-1:0] EXE_LW_OP      = ALUOP_W'(8'b11100011);
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP     = ALUOP_W'(8'b11100100);
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP     = ALUOP_W'(8'b11100101);
  localparam logic [ALUOP_W-1:0] EXE_SB_OP      = ALUOP_W'(8'b11101000);
  localparam logic [ALUOP_W-1:0] EXE_SH_OP      = ALUOP_W'(8'b11101001);
  localparam logic [ALUOP_W-1:0] EXE_SW_OP      = ALUOP_W'(8'b11101011);
  localparam logic [ALUOP_W-1:0] EXE_BREAK_OP   = ALUOP_W'(8'b00001011);
  localparam logic [ALUOP_W-1:0] EXE_SYSCALL_OP = ALUOP_W'(8'b00001100);
  localparam logic [ALUOP_W-1:0] EXE_MFC0_OP    = ALUOP_W'(8'b01011101);
  localparam logic [ALUOP_W-1:0] EXE_MTC0_OP    = ALUOP_W'(8'b01100000);
  localparam logic [ALUOP_W-1:0] EXE_ERET_OP    = ALUOP_W'(8'b01101011);

  localparam logic [4:0] BJ_NONE   = 5'd0;
  localparam logic [4:0] BJ_BEQ    = 5'd1;
  localparam logic [4:0] BJ_BNE    = 5'd2;
  localparam logic [4:0] BJ_BGTZ   = 5'd3;
  localparam logic [4:0] BJ_BLEZ   = 5'd4;
  localparam logic [4:0] BJ_BLTZ   = 5'd5;
  localparam logic [4:0] BJ_BGEZ   = 5'd6;
  localparam logic [4:0] BJ_BLTZAL = 5'd7;
  localparam logic [4:0] BJ_BGEZAL = 5'd8;
  localparam logic [4:0] BJ_J      = 5'd9;
  localparam logic [4:0] BJ_JR     = 5'd10;

  typedef struct packed {
    logic               ri;
    logic [4:0]         bj;
    logic [ALUOP_W-1:0] op;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    opc  = ins[31:26];
    rs   = ins[25:21];
    rt   = ins[20:16];
    fn   = ins[5:0];
    d.op = EXE_NOP_OP;
    d.bj = BJ_NONE;
    d.ri = 1'b0;
    case (opc)
      6'b000000: begin
        case (fn)
          6'b000000: d.op = EXE_SLL_OP;
          6'b000010: d.op = EXE_SRL_OP;
          6'b000011: d.op = EXE_SRA_OP;
          6'b000100: d.op = EXE_SLLV_OP;
          6'b000110: d.op = EXE_SRLV_OP;
          6'b000111: d.op = EXE_SRAV_OP;
          6'b001000: begin d.op = EXE_J_OP;    d.bj = BJ_JR; end
          6'b001001: begin d.op = EXE_JALR_OP; d.bj = BJ_JR; end
          6'b001100: d.op = EXE_SYSCALL_OP;
          6'b001101: d.op = EXE_BREAK_OP;
          6'b010000: d.op = EXE_MFHI_OP;
          6'b010001: d.op = EXE_MTHI_OP;
          6'b010010: d.op = EXE_MFLO_OP;
          6'b010011: d.op = EXE_MTLO_OP;
          6'b011000: d.op = EXE_MULT_OP;
          6'b011001: d.op = EXE_MULTU_OP;
          6'b011010: d.op = EXE_DIV_OP;
          6'b011011: d.op = EXE_DIVU_OP;
          6'b100000: d.op = EXE_ADD_OP;
          6'b100001: d.op = EXE_ADDU_OP;
          6'b100010: d.op = EXE_SUB_OP;
          6'b100011: d.op = EXE_SUBU_OP;
          6'b100100: d.op = EXE_AND_OP;
          6'b100101: d.op = EXE_OR_OP;
          6'b100110: d.op = EXE_XOR_OP;
          6'b100111: d.op = EXE_NOR_OP;
          6'b101010: d.op = EXE_SLT_OP;
          6'b101011: d.op = EXE_SLTU_OP;
          default:   d.ri = 1'b1;
        endcase
      end
      6'b000001: begin
        case (rt)
          5'b00000: begin d.op = EXE_BLTZ_OP;   d.bj = BJ_BLTZ;   end
          5'b00001: begin d.op = EXE_BGEZ_OP;   d.bj = BJ_BGEZ;   end
          5'b10000: begin d.op = EXE_BLTZAL_OP; d.bj = BJ_BLTZAL; end
          5'b10001: begin d.op = EXE_BGEZAL_OP; d.bj = BJ_BGEZAL; end
          default:  d.ri = 1'b1;
        endcase
      end
      // ERET is matched on the whole word before the rs-based MTC0/MFC0 split
      6'b010000: begin
        if (ins == 32'h4200_0018)  d.op = EXE_ERET_OP;
        else if (rs == 5'b00100)   d.op = EXE_MTC0_OP;
        else if (rs == 5'b00000)   d.op = EXE_MFC0_OP;
        else                       d.ri = 1'b1;
      end
      6'b000010: begin d.op = EXE_J_OP;    d.bj = BJ_J;    end
      6'b000011: begin d.op = EXE_JAL_OP;  d.bj = BJ_J;    end
      6'b000100: begin d.op = EXE_BEQ_OP;  d.bj = BJ_BEQ;  end
      6'b000101: begin d.op = EXE_BNE_OP;  d.bj = BJ_BNE;  end
      6'b000110: begin d.op = EXE_BLEZ_OP; d.bj = BJ_BLEZ; end
      6'b000111: begin d.op = EXE_BGTZ_OP; d.bj = BJ_BGTZ; end
      6'b001000: d.op = EXE_ADDI_OP;
      6'b001001: d.op = EXE_ADDIU_OP;
      6'b001010: d.op = EXE_SLTI_OP;
      6'b001011: d.op = EXE_SLTIU_OP;
      6'b001100: d.op = EXE_ANDI_OP;
      6'b001101: d.op = EXE_ORI_OP;
      6'b001110: d.op = EXE_XORI_OP;
      6'b001111: d.op = EXE_LUI_OP;
      6'b100000: d.op = EXE_LB_OP;
      6'b100001: d.op = EXE_LH_OP;
      6'b100011: d.op = EXE_LW_OP;
      6'b100100: d.op = EXE_LBU_OP;
      6'b100101: d.op = EXE_LHU_OP;
      6'b101000: d.op = EXE_SB_OP;
      6'b101001: d.op = EXE_SH_OP;
      6'b101011: d.op = EXE_SW_OP;
      default:   d.ri = 1'b1;
    endcase
    return d;
  endfunction

  dec_t              in_dec;
  logic              wr_en;
  logic              rd_en;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];
  dec_t              dec_mem_q   [DEPTH];

  assign in_dec    = decode(in_instr);
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  always_comb begin
    wr_en    = in_valid & in_ready & ~flush;
    rd_en    = out_valid & out_ready & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; out_valid alone qualifies the head
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
      dec_mem_q[wr_ptr_q]   <= in_dec;
    end
  end

  assign out_instr        = instr_mem_q[rd_ptr_q];
  assign out_pc           = pc_mem_q[rd_ptr_q];
  assign out_alucontrol   = dec_mem_q[rd_ptr_q].op;
  assign out_branch_judge = dec_mem_q[rd_ptr_q].bj;
  assign out_ri           = dec_mem_q[rd_ptr_q].ri;
  assign count            = count_q;

endmodule

// File: tb/tb_alu_decode_queue.sv
// Scoreboard bench for alu_decode_queue: stimulus pushes hand-decoded expectations,
// an independent monitor pops and compares on every output handshake.
module tb_alu_decode_queue;

  localparam logic [7:0] OP_NOP    = 8'b00000000;
  localparam logic [7:0] OP_ADD    = 8'b00100000;
  localparam logic [7:0] OP_SLL    = 8'b01111100;
  localparam logic [7:0] OP_J      = 8'b01001111;
  localparam logic [7:0] OP_BEQ    = 8'b01010001;
  localparam logic [7:0] OP_BNE    = 8'b01010010;
  localparam logic [7:0] OP_BLTZAL = 8'b01001010;
  localparam logic [7:0] OP_LW     = 8'b11100011;
  localparam logic [7:0] OP_MFC0   = 8'b01011101;
  localparam logic [7:0] OP_MTC0   = 8'b01100000;
  localparam logic [7:0] OP_ERET   = 8'b01101011;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [7:0]  out_alucontrol;
  logic [4:0]  out_branch_judge;
  logic        out_ri;
  logic [2:0]  count;

  alu_decode_queue #(.DEPTH(4), .ALUOP_W(8), .PC_W(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .in_pc            (in_pc),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .out_alucontrol   (out_alucontrol),
    .out_branch_judge (out_branch_judge),
    .out_ri           (out_ri),
    .count            (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  bj;
    logic        ri;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (resetn && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got instr %0h, expected no output", out_instr);
      end else begin
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_pc", out_pc, e.pc);
        chk("out_alucontrol", {24'd0, out_alucontrol}, {24'd0, e.op});
        chk("out_branch_judge", {27'd0, out_branch_judge}, {27'd0, e.bj});
        chk("out_ri", {31'd0, out_ri}, {31'd0, e.ri});
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [7:0] op,
                      input logic [4:0] bj, input logic ri);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc_ctr;
    e        = '{instr: instr, pc: pc_ctr, op: op, bj: bj, ri: ri};
    n        = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc_ctr   = pc_ctr + 32'd4;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk);
    #1;
    chk("count_after_drain", {29'd0, count}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    #5 resetn = 1'b1;
    @(posedge clk); #1;

    // 1) ADD into an empty queue: no bypass, visible one cycle later
    in_valid = 1'b1;
    in_instr = 32'h0085_1020;
    in_pc    = pc_ctr;
    @(negedge clk);
    chk("no_bypass_out_valid", {31'd0, out_valid}, 32'd0);
    sb.push_back('{instr: 32'h0085_1020, pc: pc_ctr, op: OP_ADD, bj: 5'd0, ri: 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc_ctr   = pc_ctr + 32'd4;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_count", {29'd0, count}, 32'd1);
    chk("t1_alucontrol", {24'd0, out_alucontrol}, {24'd0, OP_ADD});
    out_ready = 1'b1;
    drain();

    // 2) streaming: enqueue and dequeue together at count=1
    send(32'h0490_0004, OP_BLTZAL, 5'd7, 1'b0);
    send(32'h4200_0018, OP_ERET, 5'd0, 1'b0);
    chk("stream_count", {29'd0, count}, 32'd1);
    chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
    send(32'h4002_6000, OP_MFC0, 5'd0, 1'b0);
    drain();

    // 3) decode corners
    send(32'hFC00_0000, OP_NOP, 5'd0, 1'b1);
    send(32'h0000_0000, OP_SLL, 5'd0, 1'b0);
    send(32'h0000_0001, OP_NOP, 5'd0, 1'b1);
    send(32'h0402_0000, OP_NOP, 5'd0, 1'b1);
    send(32'h4040_0000, OP_NOP, 5'd0, 1'b1);
    send(32'h4080_0000, OP_MTC0, 5'd0, 1'b0);
    send(32'h03E0_0008, OP_J, 5'd10, 1'b0);
    send(32'h0800_0000, OP_J, 5'd9, 1'b0);
    send(32'h1000_0000, OP_BEQ, 5'd1, 1'b0);
    send(32'h1400_0000, OP_BNE, 5'd2, 1'b0);
    send(32'h8C00_0000, OP_LW, 5'd0, 1'b0);
    drain();

    // 4) fill to full, refuse a fifth word, drain in order; three passes to wrap pointers
    for (int pass = 0; pass < 3; pass++) begin
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++)
        send(32'h0085_1020 | (32'(pass * 4 + k) << 11), OP_ADD, 5'd0, 1'b0);
      chk("full_count", {29'd0, count}, 32'd4);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_head", out_instr, 32'h0085_1020 | (32'(pass * 4) << 11));
      in_valid = 1'b1;
      in_instr = 32'h0000_0000;
      in_pc    = 32'hDEAD_0000;
      @(posedge clk); #1;
      chk("fifth_refused", {29'd0, count}, 32'd4);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("full_refuse_with_deq", {29'd0, count}, 32'd3);
      in_valid = 1'b0;
      drain();
    end

    // 5) flush dominates an enqueue and a dequeue in the same cycle
    out_ready = 1'b0;
    send(32'h0085_1020, OP_ADD, 5'd0, 1'b0);
    send(32'h1000_0000, OP_BEQ, 5'd1, 1'b0);
    send(32'h8C00_0000, OP_LW, 5'd0, 1'b0);
    chk("pre_flush_count", {29'd0, count}, 32'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0800_0000;
    in_pc     = 32'hBAD0_0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    send(32'h4080_0000, OP_MTC0, 5'd0, 1'b0);
    drain();

    // 6) asynchronous reset between edges drops queued entries at once
    out_ready = 1'b0;
    send(32'h0085_1020, OP_ADD, 5'd0, 1'b0);
    send(32'h1400_0000, OP_BNE, 5'd2, 1'b0);
    chk("pre_reset_count", {29'd0, count}, 32'd2);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_count", {29'd0, count}, 32'd0);
    sb.delete();
    #4 resetn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0490_0004, OP_BLTZAL, 5'd7, 1'b0);
    drain();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
